solver_arbiter: RTL and testbench
=================================

SOLVER_ARBITER -- requirements
Module: solver_arbiter

Interface
REQ-001 Parameters SHALL be: N_REQ, default 4, number of requesters; TIMEOUT, default 64, maximum cycles allowed for a solver phase.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 req  input  N_REQ  per-requester request level.
REQ-005 x_in  input  8*N_REQ  packed X operands; requester i occupies slice [8*i +: 8].
REQ-006 a_in, b_in, c_in  input  16*N_REQ each  packed A, B and C operands; requester i occupies slice [16*i +: 16].
REQ-007 grant  output  N_REQ  one-cycle acceptance pulse to the winning requester.
REQ-008 done  output  N_REQ  one-cycle completion pulse to the owning requester.
REQ-009 resp_result  output  16  result of the last job.
REQ-010 resp_zero, resp_overflow, resp_timeout  output  1 each  flags of the last job.
REQ-011 resp_id  output  clog2(N_REQ)  index of the requester that owns the last job.
REQ-012 sol_start  output  1  start signal to the shared AX²+BX+C solver.
REQ-013 sol_clear  output  1  reset request to the solver.
REQ-014 sol_x  output  8  latched X operand.
REQ-015 sol_a, sol_b, sol_c  output  16 each  latched A, B and C operands.
REQ-016 sol_result  input  16  result from the solver.
REQ-017 sol_zero, sol_overflow, sol_completed  input  1 each  status from the solver.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, BUSY, RESP, RECOVER and ABORT, and SHALL run exactly one solver job at a time.
REQ-019 IDLE with any req bit sampled high: the edge SHALL pick the round-robin winner, load sol_x/a/b/c from that winner's slices, record its index, set grant[winner]=1 for the following cycle and go to ISSUE.
REQ-020 Round-robin: search starts at the index after the last granted requester and wraps from N_REQ-1 to 0; after reset the search starts at index 0.
REQ-021 A req bit dropped before its grant SHALL NOT be granted; no req in IDLE -> stay in IDLE.
REQ-022 A requester holds req and its operands until it sees grant; req still high during the grant cycle SHALL NOT cause a second grant.
REQ-023 sol_start SHALL be 1 in ISSUE and BUSY, and 0 in all other states.
REQ-024 ISSUE SHALL last one cycle, then go to BUSY.
REQ-025 On entry to BUSY a cycle counter SHALL clear to 0.
REQ-026 BUSY with sol_completed=1 sampled: the edge SHALL capture sol_result/sol_zero/sol_overflow into the resp_* outputs, set resp_timeout=0, and go to RESP.
REQ-027 RESP SHALL last one cycle with done[resp_id]=1, then go to RECOVER.
REQ-028 RECOVER SHALL go to IDLE on the first edge that samples sol_completed=0, so a back-to-back job can never see a stale completion.
REQ-029 The counter SHALL count in BUSY and RECOVER and clear on entry to each of them.
REQ-030 Reaching TIMEOUT-1 without the exit condition SHALL go to ABORT.
REQ-031 ABORT SHALL last one cycle with sol_clear=1.
REQ-032 ABORT entered from BUSY: done[resp_id]=1, resp_result=0, resp_zero=0, resp_overflow=0, resp_timeout=1.
REQ-033 ABORT entered from RECOVER: no done pulse, and resp_* unchanged.
REQ-034 ABORT SHALL go to IDLE.
REQ-035 resp_* outputs SHALL hold their values until the next RESP or ABORT.
REQ-036 At most one grant bit and one done bit SHALL be high in any cycle.
REQ-037 Minimum request-to-grant latency SHALL be 1 cycle; grant-to-done latency SHALL be 2 cycles plus the solver latency.

Reset
REQ-038 rst low SHALL immediately force: state IDLE, grant=0, done=0, sol_start=0, all resp_* =0, sol_x/a/b/c=0, round-robin pointer at 0, counter=0.
REQ-039 sol_clear SHALL be 1 combinationally while rst is low.
REQ-040 Reset mid-job SHALL abandon the job with no done pulse; the requester re-requests after reset.

Verification
REQ-041 Single job: behavioural solver with 8-cycle latency; req[0] with X=15, A=96, B=3, C=1 -> grant[0] one cycle; done[0] one cycle; resp_result=21646, resp_zero=0, resp_overflow=0, resp_id=0.
REQ-042 Contention: req=4'b1111 held with distinct operands -> grants in order 0,1,2,3, one per job; each done carries its own result and id.
REQ-043 Fairness: req[1] and req[2] held continuously -> grants alternate 1,2,1,2; no requester starved.
REQ-044 Timeout: solver never asserts completed -> after 64 BUSY cycles, sol_clear pulse 1 cycle, done with resp_timeout=1 and resp_result=0; the next request is served normally.
REQ-045 Stuck completed: completed held high after RESP -> after 64 RECOVER cycles, sol_clear pulse 1 cycle and no extra done.
REQ-046 Reset mid-BUSY: rst low for 2 cycles -> immediate zeros, sol_clear=1 during reset, no done; after reset req[3] is granted before req[0] only if it alone is asserted.

Source files
------------

// File: rtl/solver_arbiter.sv
// Round-robin arbiter that shares one AX^2+BX+C solver among N_REQ requesters,
// running one job at a time with completion, timeout and stuck-completion recovery.
module solver_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64,
    localparam int IDW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   x_in,
    input  logic [16*N_REQ-1:0]  a_in,
    input  logic [16*N_REQ-1:0]  b_in,
    input  logic [16*N_REQ-1:0]  c_in,
    output logic [N_REQ-1:0]     grant,
    output logic [N_REQ-1:0]     done,
    output logic [15:0]          resp_result,
    output logic                 resp_zero,
    output logic                 resp_overflow,
    output logic                 resp_timeout,
    output logic [IDW-1:0]       resp_id,
    output logic                 sol_start,
    output logic                 sol_clear,
    output logic [7:0]           sol_x,
    output logic [15:0]          sol_a,
    output logic [15:0]          sol_b,
    output logic [15:0]          sol_c,
    input  logic [15:0]          sol_result,
    input  logic                 sol_zero,
    input  logic                 sol_overflow,
    input  logic                 sol_completed
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        BUSY    = 3'd2,
        RESP    = 3'd3,
        RECOVER = 3'd4,
        ABORT   = 3'd5
    } state_t;

    state_t          state_r;
    logic [IDW-1:0]  rr_ptr_r;
    logic [IDW-1:0]  owner_r;
    logic [CW-1:0]   cnt_r;
    logic            sol_clear_r;

    logic            win_found_s;
    logic [IDW-1:0]  win_idx_s;
    logic [IDW-1:0]  next_ptr_s;
    logic [IDW:0]    sum_s;
    logic [IDW-1:0]  idx_s;
    logic            timeout_hit_s;

    // Round-robin search: first requester at or after rr_ptr_r, wrapping at N_REQ.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        sum_s       = '0;
        idx_s       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum_s       = {1'b0, rr_ptr_r} + (IDW+1)'(i);
            idx_s       = (sum_s >= (IDW+1)'(N_REQ)) ? IDW'(sum_s - (IDW+1)'(N_REQ))
                                                     : sum_s[IDW-1:0];
            win_idx_s   = (!win_found_s && req[idx_s]) ? idx_s : win_idx_s;
            win_found_s = win_found_s | req[idx_s];
        end
    end

    // Pointer to the index just after the winner, and the phase-timeout detector.
    always_comb begin
        next_ptr_s    = (win_idx_s == IDW'(N_REQ - 1)) ? '0 : win_idx_s + IDW'(1);
        timeout_hit_s = (cnt_r == CW'(TIMEOUT - 1));
    end

    assign sol_clear = sol_clear_r | ~rst;

    // Job FSM with every output registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= IDLE;
            rr_ptr_r      <= '0;
            owner_r       <= '0;
            cnt_r         <= '0;
            sol_clear_r   <= 1'b0;
            grant         <= '0;
            done          <= '0;
            resp_result   <= 16'd0;
            resp_zero     <= 1'b0;
            resp_overflow <= 1'b0;
            resp_timeout  <= 1'b0;
            resp_id       <= '0;
            sol_start     <= 1'b0;
            sol_x         <= 8'd0;
            sol_a         <= 16'd0;
            sol_b         <= 16'd0;
            sol_c         <= 16'd0;
        end else begin
            grant       <= '0;
            done        <= '0;
            sol_clear_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (win_found_s) begin
                        state_r   <= ISSUE;
                        grant     <= ONE_HOT0 << win_idx_s;
                        owner_r   <= win_idx_s;
                        rr_ptr_r  <= next_ptr_s;
                        sol_x     <= x_in[8*win_idx_s +: 8];
                        sol_a     <= a_in[16*win_idx_s +: 16];
                        sol_b     <= b_in[16*win_idx_s +: 16];
                        sol_c     <= c_in[16*win_idx_s +: 16];
                        sol_start <= 1'b1;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                ISSUE: begin
                    state_r   <= BUSY;
                    cnt_r     <= '0;
                    sol_start <= 1'b1;
                end
                BUSY: begin
                    if (sol_completed) begin
                        state_r       <= RESP;
                        sol_start     <= 1'b0;
                        done          <= ONE_HOT0 << owner_r;
                        resp_id       <= owner_r;
                        resp_result   <= sol_result;
                        resp_zero     <= sol_zero;
                        resp_overflow <= sol_overflow;
                        resp_timeout  <= 1'b0;
                    end else if (timeout_hit_s) begin
                        state_r       <= ABORT;
                        sol_start     <= 1'b0;
                        sol_clear_r   <= 1'b1;
                        done          <= ONE_HOT0 << owner_r;
                        resp_id       <= owner_r;
                        resp_result   <= 16'd0;
                        resp_zero     <= 1'b0;
                        resp_overflow <= 1'b0;
                        resp_timeout  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                RESP: begin
                    state_r <= RECOVER;
                    cnt_r   <= '0;
                end
                // Wait for the solver to drop completed so the next job cannot see a stale one.
                RECOVER: begin
                    if (!sol_completed) begin
                        state_r <= IDLE;
                    end else if (timeout_hit_s) begin
                        state_r     <= ABORT;
                        sol_clear_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ABORT: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r   <= IDLE;
                    sol_start <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_solver_arbiter.sv
// Scoreboard bench for solver_arbiter with a behavioural 8-cycle solver model
// that can also be made to never complete or to hold completed stuck high.
module tb_solver_arbiter;

    localparam int N = 4;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] res;
        logic        z;
        logic        o;
        logic        t;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [8*N-1:0]  x_in;
    logic [16*N-1:0] a_in, b_in, c_in;
    logic [N-1:0]  grant, done;
    logic [15:0]   resp_result;
    logic          resp_zero, resp_overflow, resp_timeout;
    logic [1:0]    resp_id;
    logic          sol_start, sol_clear;
    logic [7:0]    sol_x;
    logic [15:0]   sol_a, sol_b, sol_c;
    logic [15:0]   sol_result;
    logic          sol_zero, sol_overflow, sol_completed;

    logic          running_m;
    logic [3:0]    scnt_m;
    logic [47:0]   full_m;
    int            solver_mode;   // 0 normal, 1 never completes, 2 completed stuck

    exp_t exp_q[$];
    int   exp_grant_q[$];
    int   n_checks = 0, n_fail = 0;
    int   grant_cnt = 0, done_cnt = 0, clear_cycles = 0, cyc = 0;
    int   last_grant_cyc = 0, last_done_cyc = 0, grant_limit = 0;
    bit   hold_req = 1'b0;

    solver_arbiter #(.N_REQ(N), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .req(req),
        .x_in(x_in), .a_in(a_in), .b_in(b_in), .c_in(c_in),
        .grant(grant), .done(done),
        .resp_result(resp_result), .resp_zero(resp_zero),
        .resp_overflow(resp_overflow), .resp_timeout(resp_timeout),
        .resp_id(resp_id),
        .sol_start(sol_start), .sol_clear(sol_clear),
        .sol_x(sol_x), .sol_a(sol_a), .sol_b(sol_b), .sol_c(sol_c),
        .sol_result(sol_result), .sol_zero(sol_zero),
        .sol_overflow(sol_overflow), .sol_completed(sol_completed)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] poly(input logic [7:0] x, input logic [15:0] a,
                                         input logic [15:0] b, input logic [15:0] c);
        poly = 48'(a) * 48'(x) * 48'(x) + 48'(b) * 48'(x) + 48'(c);
    endfunction

    function automatic exp_t mk_exp(input int id, input logic [7:0] x, input logic [15:0] a,
                                    input logic [15:0] b, input logic [15:0] c);
        exp_t e;
        logic [47:0] p;
        p     = poly(x, a, b, c);
        e.id  = 2'(id);
        e.res = p[15:0];
        e.z   = (p[15:0] == 16'd0);
        e.o   = |p[47:16];
        e.t   = 1'b0;
        return e;
    endfunction

    always_comb full_m = poly(sol_x, sol_a, sol_b, sol_c);

    // Behavioural solver: completes 8 edges after it first sees start.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            running_m <= 1'b0; scnt_m <= 4'd0; sol_completed <= 1'b0;
            sol_result <= 16'd0; sol_zero <= 1'b0; sol_overflow <= 1'b0;
        end else if (sol_clear) begin
            running_m <= 1'b0; scnt_m <= 4'd0; sol_completed <= 1'b0;
        end else if (running_m) begin
            if (scnt_m == 4'd7) begin
                if (solver_mode != 1) begin
                    running_m     <= 1'b0;
                    sol_completed <= 1'b1;
                end
            end else begin
                scnt_m <= scnt_m + 4'd1;
            end
        end else if (sol_completed) begin
            if (!sol_start && solver_mode != 2) sol_completed <= 1'b0;
        end else if (sol_start) begin
            running_m    <= 1'b1;
            scnt_m       <= 4'd0;
            sol_result   <= full_m[15:0];
            sol_zero     <= (full_m[15:0] == 16'd0);
            sol_overflow <= |full_m[47:16];
        end
    end

    task automatic set_ops(input int i, input logic [7:0] x, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] c);
        x_in[8*i +: 8]  = x;
        a_in[16*i +: 16] = a;
        b_in[16*i +: 16] = b;
        c_in[16*i +: 16] = c;
    endtask

    task automatic queue_job(input int i, input logic [7:0] x, input logic [15:0] a,
                             input logic [15:0] b, input logic [15:0] c);
        set_ops(i, x, a, b, c);
        exp_grant_q.push_back(i);
        exp_q.push_back(mk_exp(i, x, a, b, c));
    endtask

    // One clock of requester behaviour plus the grant/done scoreboard.
    task automatic step();
        exp_t e;
        int   gi;
        @(negedge clk);
        cyc++;
        if (sol_clear) clear_cycles++;
        if (grant !== '0) begin
            grant_cnt++;
            last_grant_cyc = cyc;
            n_checks++;
            if (exp_grant_q.size() > 0) gi = exp_grant_q.pop_front();
            else gi = -1;
            if (gi < 0 || grant !== (4'b0001 << gi)) begin
                n_fail++;
                $display("FAIL grant_order: got grant=%b, expected requester %0d", grant, gi);
            end
            if (!hold_req) req = req & ~grant;
            if (grant_limit > 0 && grant_cnt >= grant_limit) req = '0;
        end
        if (done !== '0) begin
            done_cnt++;
            last_done_cyc = cyc;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: got done=%b id=%0d, expected none", done, resp_id);
            end else begin
                e = exp_q.pop_front();
                if (done !== (4'b0001 << e.id) || resp_id !== e.id || resp_result !== e.res ||
                    resp_zero !== e.z || resp_overflow !== e.o || resp_timeout !== e.t) begin
                    n_fail++;
                    $display("FAIL done_resp: got done=%b id=%0d res=%0d z=%b o=%b t=%b, expected id=%0d res=%0d z=%b o=%b t=%b",
                             done, resp_id, resp_result, resp_zero, resp_overflow, resp_timeout,
                             e.id, e.res, e.z, e.o, e.t);
                end
            end
        end
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((exp_q.size() > 0 || exp_grant_q.size() > 0) && k < budget) begin
            step();
            k++;
        end
        n_checks++;
        if (exp_q.size() > 0 || exp_grant_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d dones and %0d grants outstanding, expected 0",
                     exp_q.size(), exp_grant_q.size());
        end
        exp_q.delete();
        exp_grant_q.delete();
        repeat (4) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; x_in = '0; a_in = '0; b_in = '0; c_in = '0; solver_mode = 0;
        #2 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({grant, done, sol_start} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: grant=%b done=%b start=%b, expected all 0", grant, done, sol_start);
        end
        n_checks++;
        if (sol_clear !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_clear: sol_clear=%b, expected 1", sol_clear);
        end
        n_checks++;
        if ({resp_result, resp_zero, resp_overflow, resp_timeout, resp_id} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_resp: res=%0d z=%b o=%b t=%b id=%0d, expected 0",
                     resp_result, resp_zero, resp_overflow, resp_timeout, resp_id);
        end
        rst = 1'b1;
        step();
        n_checks++;
        if (sol_clear !== 1'b0 || sol_start !== 1'b0 || {sol_x, sol_a, sol_b, sol_c} !== 56'd0) begin
            n_fail++;
            $display("FAIL post_reset: clear=%b start=%b x=%0d a=%0d, expected 0",
                     sol_clear, sol_start, sol_x, sol_a);
        end
    endtask

    task automatic test_contention();
        int g0 = grant_cnt, d0 = done_cnt;
        queue_job(0, 8'd15, 16'd96, 16'd3, 16'd1);
        queue_job(1, 8'd2, 16'd1000, 16'd7, 16'd5);
        queue_job(2, 8'd0, 16'd0, 16'd0, 16'd0);
        queue_job(3, 8'd255, 16'hFFFF, 16'd0, 16'd0);
        req = 4'b1111;
        drain(400);
        n_checks++;
        if (grant_cnt - g0 != 4 || done_cnt - d0 != 4) begin
            n_fail++;
            $display("FAIL contention_count: grants=%0d dones=%0d, expected 4 and 4",
                     grant_cnt - g0, done_cnt - d0);
        end
    endtask

    task automatic test_single();
        int g0 = grant_cnt;
        queue_job(0, 8'd15, 16'd96, 16'd3, 16'd1);
        req = 4'b0001;
        step();
        n_checks++;
        if (grant_cnt - g0 != 1 || sol_x !== 8'd15 || sol_a !== 16'd96 || sol_b !== 16'd3 ||
            sol_c !== 16'd1 || sol_start !== 1'b1) begin
            n_fail++;
            $display("FAIL single_issue: grants=%0d x=%0d a=%0d b=%0d c=%0d start=%b, expected 1 15 96 3 1 1",
                     grant_cnt - g0, sol_x, sol_a, sol_b, sol_c, sol_start);
        end
        drain(200);
        n_checks++;
        if (last_done_cyc - last_grant_cyc != 10) begin
            n_fail++;
            $display("FAIL single_latency: grant-to-done=%0d, expected 10", last_done_cyc - last_grant_cyc);
        end
        n_checks++;
        if (resp_result !== 16'd21646 || resp_id !== 2'd0 || resp_zero !== 1'b0 || resp_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL single_hold: res=%0d id=%0d z=%b o=%b, expected 21646 0 0 0",
                     resp_result, resp_id, resp_zero, resp_overflow);
        end
    endtask

    task automatic test_fairness();
        set_ops(1, 8'd3, 16'd10, 16'd20, 16'd30);
        set_ops(2, 8'd4, 16'd5, 16'd6, 16'd7);
        for (int k = 0; k < 2; k++) begin
            exp_grant_q.push_back(1);
            exp_q.push_back(mk_exp(1, 8'd3, 16'd10, 16'd20, 16'd30));
            exp_grant_q.push_back(2);
            exp_q.push_back(mk_exp(2, 8'd4, 16'd5, 16'd6, 16'd7));
        end
        hold_req = 1'b1;
        grant_limit = grant_cnt + 4;
        req = 4'b0110;
        drain(600);
        hold_req = 1'b0;
        grant_limit = 0;
    endtask

    task automatic test_timeout();
        exp_t e;
        solver_mode = 1;
        set_ops(2, 8'd9, 16'd9, 16'd9, 16'd9);
        exp_grant_q.push_back(2);
        e = '{id: 2'd2, res: 16'd0, z: 1'b0, o: 1'b0, t: 1'b1};
        exp_q.push_back(e);
        clear_cycles = 0;
        req = 4'b0100;
        drain(300);
        n_checks++;
        if (clear_cycles != 1 || last_done_cyc - last_grant_cyc != 65) begin
            n_fail++;
            $display("FAIL timeout_abort: clear_cycles=%0d grant-to-done=%0d, expected 1 and 65",
                     clear_cycles, last_done_cyc - last_grant_cyc);
        end
        solver_mode = 0;
        queue_job(3, 8'd7, 16'd2, 16'd3, 16'd4);
        req = 4'b1000;
        drain(200);
        n_checks++;
        if (resp_timeout !== 1'b0 || resp_result !== 16'd123) begin
            n_fail++;
            $display("FAIL timeout_recovery: t=%b res=%0d, expected 0 and 123", resp_timeout, resp_result);
        end
    endtask

    task automatic test_stuck();
        int d0;
        solver_mode = 2;
        queue_job(1, 8'd10, 16'd1, 16'd1, 16'd1);
        clear_cycles = 0;
        d0 = done_cnt;
        req = 4'b0010;
        drain(200);
        repeat (75) step();
        n_checks++;
        if (clear_cycles != 1 || done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL stuck_recover: clear_cycles=%0d dones=%0d, expected 1 and 1",
                     clear_cycles, done_cnt - d0);
        end
        n_checks++;
        if (resp_result !== 16'd111 || resp_timeout !== 1'b0 || resp_id !== 2'd1) begin
            n_fail++;
            $display("FAIL stuck_resp_hold: res=%0d t=%b id=%0d, expected 111 0 1",
                     resp_result, resp_timeout, resp_id);
        end
        solver_mode = 0;
    endtask

    task automatic test_reset_mid();
        set_ops(0, 8'd5, 16'd5, 16'd5, 16'd5);
        exp_grant_q.push_back(0);
        req = 4'b0001;
        repeat (3) step();
        rst = 1'b0;
        #1;
        n_checks++;
        if ({grant, done, sol_start} !== 9'd0 || sol_clear !== 1'b1 ||
            {resp_result, resp_zero, resp_overflow, resp_timeout, resp_id} !== 21'd0 ||
            {sol_x, sol_a, sol_b, sol_c} !== 56'd0) begin
            n_fail++;
            $display("FAIL mid_reset_zero: grant=%b done=%b start=%b clear=%b res=%0d x=%0d, expected zeros and clear=1",
                     grant, done, sol_start, sol_clear, resp_result, sol_x);
        end
        repeat (2) step();
        n_checks++;
        if (sol_clear !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_clear: sol_clear=%b, expected 1", sol_clear);
        end
        rst = 1'b1;
        queue_job(0, 8'd1, 16'd1, 16'd1, 16'd1);
        queue_job(3, 8'd2, 16'd2, 16'd2, 16'd2);
        req = 4'b1001;
        drain(400);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_fairness();
        test_timeout();
        test_stuck();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
